present_dec_80: RTL and testbench

Iterative PRESENT-80 decryption core: the inverse counterpart of the team's parallel 16-nibble S-box layer used on the encrypt side. It accepts a 64-bit ciphertext and 80-bit key over a valid/ready handshake. It derives the final round key by running the key schedule forward, then unwinds 31 rounds (inverse pLayer, inverse S-box layer, inverse key update) at one round per cycle. It sits on the receive path, downstream of the link deframer and upstream of the plaintext buffer.

---
 rtl/present_pkg.sv | 69 ++++++
 rtl/present_inv_sbox.sv | 17 +
 rtl/present_sbox.sv | 17 +
 rtl/present_dec_80.sv | 234 +++++++++++++++++++++++
 tb/tb_present_dec_80.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/present_pkg.sv
`default_nettype none
// ============================================================================
//  present_pkg
//  Shared constants, S-box tables, FSM encoding and bit-level helpers for
//  the PRESENT-80 cipher cores.
//  Revision: 1.0
// ============================================================================
package present_pkg;

    localparam int ROUNDS = 31;
    localparam int KEY_W  = 80;
    localparam int BLK_W  = 64;

    localparam logic [4:0] CTR_FIRST = 5'd1;
    localparam logic [4:0] CTR_LAST  = 5'd31;

    // Forward S-box, indexed by input nibble
    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    // Inverse S-box, indexed by input nibble
    localparam logic [3:0] SBOX_INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Inverse pLayer: result bit j is taken from input bit 16*j mod 63
    function automatic logic [BLK_W-1:0] p_inv(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        int unsigned      idx;
        r = '0;
        for (int j = 0; j < 63; j++) begin
            idx  = (16 * j) % 63;
            r[j] = s[idx[5:0]];
        end
        r[63] = s[63];
        return r;
    endfunction

    // Key register rotated left by 61 positions
    function automatic logic [KEY_W-1:0] key_rotl61(input logic [KEY_W-1:0] k);
        return {k[18:0], k[79:19]};
    endfunction

    // Key register rotated right by 61 positions
    function automatic logic [KEY_W-1:0] key_rotr61(input logic [KEY_W-1:0] k);
        return {k[60:0], k[79:61]};
    endfunction

    // Round counter folded into key bits 19:15 (self-inverse)
    function automatic logic [KEY_W-1:0] key_xor_ctr(input logic [KEY_W-1:0] k,
                                                     input logic [4:0]       ctr);
        logic [KEY_W-1:0] r;
        r        = k;
        r[19:15] = k[19:15] ^ ctr;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/present_inv_sbox.sv
`default_nettype none
// ============================================================================
//  present_inv_sbox
//  4-bit combinational PRESENT inverse S-box.
//  Revision: 1.0
// ============================================================================
module present_inv_sbox
    import present_pkg::*;
(
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    assign nib_out = SBOX_INV[nib_in];

endmodule
`default_nettype wire

// File: rtl/present_sbox.sv
`default_nettype none
// ============================================================================
//  present_sbox
//  4-bit combinational PRESENT forward S-box.
//  Revision: 1.0
// ============================================================================
module present_sbox
    import present_pkg::*;
(
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    assign nib_out = SBOX[nib_in];

endmodule
`default_nettype wire

// File: rtl/present_dec_80.sv
`default_nettype none
// ============================================================================
//  present_dec_80
//  Iterative PRESENT-80 decryption core, one round per cycle. The final round
//  key is derived by running the key schedule forward (KEYEXP), then 31
//  rounds are unwound (ROUND) while the schedule is stepped backwards.
//  Optional feature macro: PRESENT_DEC_KEYCACHE_EN -- remembers the last
//  expanded key so a repeated key skips KEYEXP (accept-to-valid then equals
//  the ROUND phase only).
//  Revision: 1.0
// ============================================================================
module present_dec_80
    import present_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] cipher_in,
    input  logic [KEY_W-1:0] key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] plain_out
);

    state_e           fsm_q, fsm_d;
    logic [BLK_W-1:0] state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [4:0]       ctr_q, ctr_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             release_out;
    logic             cache_hit;

    logic [KEY_W-1:0] key_rot;
    logic [3:0]       fwd_nib;
    logic [KEY_W-1:0] key_fwd;
    logic [KEY_W-1:0] key_x;
    logic [3:0]       inv_nib;
    logic [KEY_W-1:0] key_inv;
    logic [BLK_W-1:0] perm;
    logic [BLK_W-1:0] sub;
    logic [BLK_W-1:0] state_round;

    // in_ready_q gates acceptance so nothing is taken before in_ready is visible
    assign accept      = (fsm_q == ST_IDLE) && in_ready_q && in_valid;
    assign release_out = (fsm_q == ST_DONE) && out_ready;

    // ---------------- forward key step (KEYEXP) ----------------
    assign key_rot = key_rotl61(key_q);

    present_sbox u_key_sbox (
        .nib_in  (key_rot[79:76]),
        .nib_out (fwd_nib)
    );

    assign key_fwd = key_xor_ctr({fwd_nib, key_rot[75:0]}, ctr_q);

    // ---------------- inverse key step (ROUND) ----------------
    assign key_x = key_xor_ctr(key_q, ctr_q);

    present_inv_sbox u_key_inv_sbox (
        .nib_in  (key_x[79:76]),
        .nib_out (inv_nib)
    );

    assign key_inv = key_rotr61({inv_nib, key_x[75:0]});

    // ---------------- inverse round datapath ----------------
    assign perm = p_inv(state_q);

    generate
        for (genvar n = 0; n < 16; n++) begin : g_inv_sbox
            present_inv_sbox u_inv_sbox (
                .nib_in  (perm[4*n +: 4]),
                .nib_out (sub[4*n +: 4])
            );
        end
    endgenerate

    assign state_round = sub ^ key_inv[79:16];

`ifdef PRESENT_DEC_KEYCACHE_EN
    logic [KEY_W-1:0] cached_key_q, cached_key_d;
    logic [KEY_W-1:0] cached_k32_q, cached_k32_d;
    logic             cache_vld_q, cache_vld_d;

    assign cache_hit = cache_vld_q && (key_in == cached_key_q);

    // Cache: key captured on a miss accept, validated once its K32 is known
    always_comb begin
        cached_key_d = cached_key_q;
        cached_k32_d = cached_k32_q;
        cache_vld_d  = cache_vld_q;
        if (accept && !cache_hit) begin
            cached_key_d = key_in;
            cache_vld_d  = 1'b0;
        end
        if ((fsm_q == ST_KEYEXP) && (ctr_q == CTR_LAST)) begin
            cached_k32_d = key_fwd;
            cache_vld_d  = 1'b1;
        end
    end

    // Cache registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cached_key_q <= '0;
            cached_k32_q <= '0;
            cache_vld_q  <= 1'b0;
        end else begin
            cached_key_q <= cached_key_d;
            cached_k32_q <= cached_k32_d;
            cache_vld_q  <= cache_vld_d;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: begin
                if (accept) begin
                    fsm_d = cache_hit ? ST_ROUND : ST_KEYEXP;
                end
            end
            ST_KEYEXP: begin
                if (ctr_q == CTR_LAST) begin
                    fsm_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (ctr_q == CTR_FIRST) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (release_out) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // Output decode, registered one step ahead from the next state
    always_comb begin
        in_ready_d  = (fsm_d == ST_IDLE);
        out_valid_d = (fsm_d == ST_DONE);
    end

    // Datapath next values: block state, key register and round counter
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        ctr_d   = ctr_q;
        case (fsm_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef PRESENT_DEC_KEYCACHE_EN
                    if (cache_hit) begin
                        state_d = cipher_in ^ cached_k32_q[79:16];
                        key_d   = cached_k32_q;
                        ctr_d   = CTR_LAST;
                    end else begin
                        state_d = cipher_in;
                        key_d   = key_in;
                        ctr_d   = CTR_FIRST;
                    end
`else
                    state_d = cipher_in;
                    key_d   = key_in;
                    ctr_d   = CTR_FIRST;
`endif
                end
            end
            ST_KEYEXP: begin
                key_d = key_fwd;
                if (ctr_q == CTR_LAST) begin
                    // Final forward step yields K32: apply output whitening
                    state_d = state_q ^ key_fwd[79:16];
                end else begin
                    ctr_d = ctr_q + 5'd1;
                end
            end
            ST_ROUND: begin
                key_d   = key_inv;
                state_d = state_round;
                if (ctr_q != CTR_FIRST) begin
                    ctr_d = ctr_q - 5'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= '0;
            key_q       <= '0;
            ctr_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            ctr_q       <= ctr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    // Only a finished block is ever visible on plain_out
    assign plain_out = out_valid_q ? state_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_present_dec_80.sv
`default_nettype none
// ============================================================================
//  tb_present_dec_80
//  Self-checking bench for present_dec_80. Reference: a plain PRESENT-80
//  encryption model; DUT must decrypt model ciphertexts back to plaintext.
//  Revision: 1.0
// ============================================================================
module tb_present_dec_80;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] cipher_in;
    logic [79:0] key_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plain_out;

    int n_vec;
    int n_err;

    localparam logic [63:0] SB_PACKED = 64'h2174_8FE3_DA09_B65C;
    localparam logic [79:0] K_ZERO    = 80'h0;
    localparam logic [79:0] K_ONES    = {80{1'b1}};
    localparam logic [63:0] P_ZERO    = 64'h0;
    localparam logic [63:0] P_ONES    = {64{1'b1}};

    present_dec_80 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cipher_in (cipher_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .plain_out (plain_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] sb(input logic [3:0] v);
        return SB_PACKED[4*v +: 4];
    endfunction

    // Straightforward PRESENT-80 encryption
    function automatic logic [63:0] model_enc(input logic [63:0] pt, input logic [79:0] k0);
        logic [63:0] s, t;
        logic [79:0] k;
        logic [4:0]  rc;
        s = pt;
        k = k0;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sb(s[4*n +: 4]);
            t = '0;
            for (int i = 0; i < 63; i++) t[(16*i) % 63] = s[i];
            t[63] = s[63];
            s = t;
            k = {k[18:0], k[79:19]};
            k[79:76] = sb(k[79:76]);
            rc = r[4:0];
            k[19:15] = k[19:15] ^ rc;
        end
        return s ^ k[79:16];
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer a block and return once the accepting edge has passed (#1 after it)
    task automatic send(input logic [63:0] c, input logic [79:0] k);
        int guard;
        in_valid  = 1'b1;
        cipher_in = c;
        key_in    = k;
        guard     = 0;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) check("send_timeout", 80'(guard), 80'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid is seen
    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic take_output;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_block(input string tag, input logic [63:0] c,
                             input logic [79:0] k, input logic [63:0] exp_pt);
        int lat;
        send(c, k);
        wait_valid(lat);
        check({tag, "_latency"}, 80'(lat), 80'd62);
        check({tag, "_plain"}, 80'(plain_out), 80'(exp_pt));
        take_output();
    endtask

    initial begin
        int          lat;
        logic [31:0] a, b, d;
        logic [63:0] pt;
        logic [79:0] k;

        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cipher_in = '0;
        key_in    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 80'(in_ready), 80'd0);
        check("rst_out_valid", 80'(out_valid), 80'd0);
        check("rst_plain", 80'(plain_out), 80'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 80'(in_ready), 80'd1);

        // Known-answer vectors
        run_block("kat_k0", 64'h5579C1387B228445, K_ZERO, P_ZERO);
        run_block("kat_kF", 64'hE72C46C0F5945049, K_ONES, P_ZERO);

        // Back-to-back with out_ready held high
        out_ready = 1'b1;
        send(64'hA112FFC72F68417B, K_ZERO);
        in_valid  = 1'b1;
        cipher_in = 64'h3333DCD3213210D2;
        key_in    = K_ONES;
        wait_valid(lat);
        check("b2b_first_latency", 80'(lat), 80'd62);
        check("b2b_first_plain", 80'(plain_out), 80'(P_ONES));
        check("b2b_in_ready_in_done", 80'(in_ready), 80'd0);
        @(posedge clk);
        #1;
        check("b2b_in_ready_after_hs", 80'({in_ready, out_valid}), 80'b10);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check("b2b_second_latency", 80'(lat), 80'd62);
        check("b2b_second_plain", 80'(plain_out), 80'(P_ONES));
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Downstream stall: output held, new input ignored
        send(64'h5579C1387B228445, K_ZERO);
        wait_valid(lat);
        in_valid  = 1'b1;
        cipher_in = 64'hE72C46C0F5945049;
        key_in    = K_ONES;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_plain", 80'(plain_out), 80'(P_ZERO));
            check("stall_ready_valid", 80'({in_ready, out_valid}), 80'b01);
        end
        in_valid = 1'b0;
        take_output();
        check("stall_released", 80'({in_ready, out_valid}), 80'b10);

        // Reset in the middle of a decryption
        send(64'hE72C46C0F5945049, K_ONES);
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 80'(out_valid), 80'd0);
        check("abort_in_ready", 80'(in_ready), 80'd0);
        check("abort_plain", 80'(plain_out), 80'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_idle_ready", 80'({in_ready, out_valid}), 80'b10);
        run_block("after_abort", 64'hA112FFC72F68417B, K_ZERO, P_ONES);

        // Random blocks against the encryption model
        for (int r = 0; r < 5; r++) begin
            a  = $urandom;
            b  = $urandom;
            d  = $urandom;
            pt = {a, b};
            a  = $urandom;
            k  = {d[15:0], a, b ^ 32'h5A5A_A5A5};
            run_block("random", model_enc(pt, k), k, pt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
